// File: rtl/shaper_pkg.sv
// Shared types and constants for the pulse shaper.
//   state_t : FSM state encoding (IDLE, HIGH, LOW)
//   CNT_W   : default width of the phase counter and of the pending-request count
package shaper_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter holding the number of queued trigger requests.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one request (dropped when the count is already at MAX)
//   dec        : remove one request (ignored when the count is zero)
//   cnt        : current count
//   overflow   : registered one-cycle flag, high the cycle after a dropped inc
// inc and dec together leave the count unchanged.
module sat_updown_cnt #(
   parameter int W   = 8,
   parameter int MAX = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         overflow
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;
   logic         overflow_q, overflow_d;

   always_comb begin
      cnt_d      = cnt_q;
      overflow_d = 1'b0;
      if (inc && !dec) begin
         if (cnt_q == MAX_V) begin
            overflow_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (dec && !inc) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign cnt      = cnt_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/pulse_shaper_moore.sv
// Moore FSM that stretches single-cycle trigger requests into output pulses
// HIGH_CYCLES wide, each followed by at least LOW_CYCLES low. Requests that
// arrive while a pulse is in progress are queued (up to MAX_PEND).
//   clk, rst_n : clock, asynchronous active-low reset
//   trig       : one request per cycle with trig=1
//   out        : shaped pulse, 1 while in HIGH
//   busy       : 1 while not IDLE
//   pend_cnt   : number of queued requests
//   overflow   : one-cycle pulse the cycle after a request was dropped
//   dbg_state  : current state register
module pulse_shaper_moore
   import shaper_pkg::*;
#(
   parameter int HIGH_CYCLES = 4,
   parameter int LOW_CYCLES  = 2,
   parameter int MAX_PEND    = 3,
   parameter int CNT_W       = shaper_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   output logic             out,
   output logic             busy,
   output logic [CNT_W-1:0] pend_cnt,
   output logic             overflow,
   output state_t           dbg_state
);

   // Counters count down to zero, so a phase of N cycles loads N-1.
   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             q_inc, q_dec;
   logic             pend_nz;

   assign pend_nz = (pend_cnt != '0);

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      phase_d = phase_q;
      q_inc   = 1'b0;
      q_dec   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A trigger from IDLE starts a pulse directly and is never queued.
            if (trig) begin
               state_d = HIGH;
               phase_d = HIGH_LOAD;
            end
         end
         HIGH: begin
            q_inc = trig;
            if (phase_q == '0) begin
               state_d = LOW;
               phase_d = LOW_LOAD;
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         LOW: begin
            if (phase_q == '0) begin
               if (pend_nz || trig) begin
                  // Back-to-back pulse: a queued request is preferred. If one
                  // is taken, a same-cycle trig is queued in its place
                  // (inc+dec holds); otherwise trig itself is consumed.
                  state_d = HIGH;
                  phase_d = HIGH_LOAD;
                  q_dec   = pend_nz;
                  q_inc   = trig && pend_nz;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               q_inc   = trig;
               phase_d = phase_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
         end
      endcase

      // Outputs are flopped from the next state so they leave the same edge
      // as the state register and never glitch.
      out_d  = (state_d == HIGH);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         phase_q <= phase_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   sat_updown_cnt #(
      .W   (CNT_W),
      .MAX (MAX_PEND)
   ) u_pend (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (q_inc),
      .dec      (q_dec),
      .cnt      (pend_cnt),
      .overflow (overflow)
   );

   assign out       = out_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_shaper_moore.sv
module tb_pulse_shaper_moore;
   import shaper_pkg::*;

   logic       clk;
   logic       rst_n;

   // Instance A: default parameters (4 high, 2 low, 3 pending)
   logic       trig_a, out_a, busy_a, ovf_a;
   logic [7:0] pend_a;
   state_t     state_a;

   // Instance B: 1 high, 1 low, 3 pending
   logic       trig_b, out_b, busy_b, ovf_b;
   logic [7:0] pend_b;
   state_t     state_b;

   int n_vec;
   int n_err;

   typedef struct {
      logic       trig;
      logic       exp_out;
      logic       exp_busy;
      logic [7:0] exp_pend;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[$];
   int   seg_start[$];

   pulse_shaper_moore #(
      .HIGH_CYCLES (4),
      .LOW_CYCLES  (2),
      .MAX_PEND    (3),
      .CNT_W       (8)
   ) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (trig_a),
      .out       (out_a),
      .busy      (busy_a),
      .pend_cnt  (pend_a),
      .overflow  (ovf_a),
      .dbg_state (state_a)
   );

   pulse_shaper_moore #(
      .HIGH_CYCLES (1),
      .LOW_CYCLES  (1),
      .MAX_PEND    (3),
      .CNT_W       (8)
   ) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (trig_b),
      .out       (out_b),
      .busy      (busy_b),
      .pend_cnt  (pend_b),
      .overflow  (ovf_b),
      .dbg_state (state_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic t, input logic o, input logic b, input int p, input logic v);
      vec_t x;
      x.trig     = t;
      x.exp_out  = o;
      x.exp_busy = b;
      x.exp_pend = 8'(p);
      x.exp_ovf  = v;
      vecs.push_back(x);
   endtask

   // Checks all outputs of instance A against one expectation.
   task automatic check_a(input string tag, input int c, input logic o, input logic b,
                          input int p, input logic v);
      check($sformatf("%s c%0d out", tag, c), {31'd0, out_a}, {31'd0, o});
      check($sformatf("%s c%0d busy", tag, c), {31'd0, busy_a}, {31'd0, b});
      check($sformatf("%s c%0d pend", tag, c), {24'd0, pend_a}, p);
      check($sformatf("%s c%0d ovf", tag, c), {31'd0, ovf_a}, {31'd0, v});
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      trig_a = 1'b0;
      trig_b = 1'b0;

      // Single trigger from IDLE
      seg_start.push_back(vecs.size());
      for (int c = 0; c <= 8; c++)
         add(c == 0, c inside {[1:4]}, c inside {[1:6]}, 0, 1'b0);

      // Triggers at cycles 0,1,2: two queued, served back to back
      seg_start.push_back(vecs.size());
      for (int c = 0; c <= 20; c++) begin
         int p;
         if (c < 2)        p = 0;
         else if (c == 2)  p = 1;
         else if (c <= 6)  p = 2;
         else if (c <= 12) p = 1;
         else              p = 0;
         add(c <= 2, c inside {[1:4], [7:10], [13:16]}, c inside {[1:18]}, p, 1'b0);
      end

      // Trigger held for cycles 0..5: saturation and two drops
      seg_start.push_back(vecs.size());
      for (int c = 0; c <= 25; c++) begin
         int p;
         if (c < 2)        p = 0;
         else if (c == 2)  p = 1;
         else if (c == 3)  p = 2;
         else if (c <= 6)  p = 3;
         else if (c <= 12) p = 2;
         else if (c <= 18) p = 1;
         else              p = 0;
         add(c <= 5, c inside {[1:4], [7:10], [13:16], [19:22]}, c inside {[1:24]}, p,
             c inside {5, 6});
      end

      // Reset state
      #2;
      check_a("reset", 0, 1'b0, 1'b0, 0, 1'b0);
      check("reset state_a", {30'd0, state_a}, {30'd0, IDLE});
      check("reset out_b", {31'd0, out_b}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven segments
      for (int i = 0; i < vecs.size(); i++) begin
         int seg;
         seg = 0;
         for (int s = 0; s < seg_start.size(); s++)
            if (i >= seg_start[s]) seg = s;
         @(negedge clk);
         check_a($sformatf("tbl%0d", seg), i - seg_start[seg], vecs[i].exp_out,
                 vecs[i].exp_busy, vecs[i].exp_pend, vecs[i].exp_ovf);
         trig_a = vecs[i].trig;
      end
      @(negedge clk);
      trig_a = 1'b0;

      // Trigger exactly on the last LOW cycle: no IDLE cycle in between
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         check_a("lowexit", c, c inside {[1:4], [7:10]}, c inside {[1:12]}, 0, 1'b0);
         if (c == 7)
            check("lowexit c7 state", {30'd0, state_a}, {30'd0, HIGH});
         trig_a = (c == 0 || c == 6);
      end
      trig_a = 1'b0;

      // Asynchronous reset mid-pulse with two requests queued
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         trig_a = (c <= 2);
      end
      check("prereset pend", {24'd0, pend_a}, 32'd2);
      check("prereset out", {31'd0, out_a}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_a("asyncrst", 0, 1'b0, 1'b0, 0, 1'b0);
      check("asyncrst state", {30'd0, state_a}, {30'd0, IDLE});
      @(negedge clk);
      check_a("asyncrst", 1, 1'b0, 1'b0, 0, 1'b0);
      rst_n = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         check_a("postrst", c, c inside {[1:4]}, c inside {[1:6]}, 0, 1'b0);
         trig_a = (c == 0);
      end
      trig_a = 1'b0;

      // Instance B: 1 high / 1 low, continuous trigger
      for (int c = 0; c <= 15; c++) begin
         int p;
         p = (c < 2) ? 0 : ((c / 2 > 3) ? 3 : c / 2);
         @(negedge clk);
         check($sformatf("fast c%0d out", c), {31'd0, out_b}, {31'd0, (c % 2) == 1});
         check($sformatf("fast c%0d busy", c), {31'd0, busy_b}, {31'd0, c >= 1});
         check($sformatf("fast c%0d pend", c), {24'd0, pend_b}, p);
         check($sformatf("fast c%0d ovf", c), {31'd0, ovf_b},
               {31'd0, (c >= 8) && ((c % 2) == 0)});
         trig_b = 1'b1;
      end
      trig_b = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
